// File: rtl/td4_pkg.sv
// Shared TD4 definitions: run-mode encoding used by the mother board, the IO
// decode and the clock controller, the clock-controller state encoding, and
// width helpers for counters sized from parameters.
package td4_pkg;

  // Run-mode switch encoding as it appears on the mode pins.
  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_SLOW = 2'b01,
    MODE_FAST = 2'b10,
    MODE_STEP = 2'b11
  } clk_mode_t;

  // Clock-controller FSM states, one per run mode.
  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_SLOW = 2'b01,
    S_FAST = 2'b10,
    S_STEP = 2'b11
  } clk_state_t;

  // Bits needed to hold 0..range_hi-1, never less than one bit.
  function automatic int unsigned width_min1(input int unsigned range_hi);
    if (range_hi <= 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(range_hi);
    end
  endfunction

  // Divider width: the SLOW divisor is the largest one the counter must hold.
  function automatic int unsigned div_width(input int unsigned clk_hz,
                                            input int unsigned slow_hz);
    return width_min1(clk_hz / slow_hz);
  endfunction

  // Map the switch setting onto the FSM state it selects.
  function automatic clk_state_t decode_mode(input clk_mode_t m);
    case (m)
      MODE_HALT: return S_HALT;
      MODE_SLOW: return S_SLOW;
      MODE_FAST: return S_FAST;
      MODE_STEP: return S_STEP;
      default:   return S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/debounce.sv
// Push-button conditioner: multi-flop synchroniser followed by a
// counter-based debouncer. The debounced level only flips after DEBOUNCE_CYC
// consecutive synchronised samples that disagree with it.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   din  - raw asynchronous button input
//   dout - debounced level (registered)
//   rise - one-cycle pulse in the cycle dout goes 0 -> 1 (registered)
// SYNC_STAGES must be at least 2.
module debounce
  import td4_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int unsigned     DW      = width_min1(DEBOUNCE_CYC);
  localparam logic [DW-1:0]   DB_TERM = DW'(DEBOUNCE_CYC - 32'd1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_out_s;
  logic                   differs_s;
  logic                   flip_s;
  logic [DW-1:0]          db_cnt_r;
  logic                   dout_r;
  logic                   rise_r;

  // Compare the synchronised sample against the accepted level.
  always_comb begin
    sync_out_s = sync_r[SYNC_STAGES-1];
    differs_s  = (sync_out_s != dout_r);
    // The sample arriving while the counter sits at its terminal value is the
    // DEBOUNCE_CYC-th consecutive disagreeing one.
    flip_s     = differs_s && (db_cnt_r == DB_TERM);
  end

  // Synchroniser shift chain; din enters at bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
    end
  end

  // Stability counter, accepted level and rising-edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_r <= {DW{1'b0}};
      dout_r   <= 1'b0;
      rise_r   <= 1'b0;
    end else if (flip_s) begin
      db_cnt_r <= {DW{1'b0}};
      dout_r   <= sync_out_s;
      rise_r   <= sync_out_s;
    end else if (differs_s) begin
      db_cnt_r <= db_cnt_r + DW'(1'b1);
      dout_r   <= dout_r;
      rise_r   <= 1'b0;
    end else begin
      db_cnt_r <= {DW{1'b0}};
      dout_r   <= dout_r;
      rise_r   <= 1'b0;
    end
  end

  assign dout = dout_r;
  assign rise = rise_r;

endmodule

// File: rtl/clock_ctrl.sv
// CPU clock-enable generator. Everything stays on clk; the CPU qualifies its
// register updates with the one-cycle tick pulse. Run modes: HALT (no ticks),
// SLOW / FAST (divided auto-run), STEP (one tick per debounced button press).
// Ports:
//   clk        - board clock, rising edge
//   rst        - synchronous active-high reset
//   mode       - 00 HALT, 01 SLOW, 10 FAST, 11 STEP (quasi-static switch)
//   step_btn   - raw asynchronous step push button, active-high
//   halt_req   - CPU halt level; suppresses auto-run ticks
//   tick       - one-cycle clock-enable pulse to the CPU
//   running    - SLOW/FAST active and not halted
//   tick_count - wrapping count of issued ticks
module clock_ctrl
  import td4_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned SLOW_HZ      = 1,
  parameter int unsigned FAST_HZ      = 10,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       step_btn,
  input  logic       halt_req,
  output logic       tick,
  output logic       running,
  output logic [7:0] tick_count
);

  localparam int unsigned   CW        = div_width(CLK_HZ, SLOW_HZ);
  localparam logic [CW-1:0] SLOW_TERM = CW'(CLK_HZ / SLOW_HZ - 32'd1);
  localparam logic [CW-1:0] FAST_TERM = CW'(CLK_HZ / FAST_HZ - 32'd1);

  clk_mode_t     mode_s;
  clk_mode_t     mode_r;
  clk_state_t    state_r;
  clk_state_t    state_next_s;
  logic          mode_chg_s;
  logic          auto_s;
  logic          div_hold_s;
  logic          halt_r;
  logic [CW-1:0] div_term_s;
  logic [CW-1:0] div_cnt_r;
  logic [CW-1:0] div_cnt_next_s;
  logic          tick_r;
  logic          tick_next_s;
  logic          running_r;
  logic          running_next_s;
  logic [7:0]    tick_count_r;
  logic          btn_level_s;
  logic          btn_rise_s;

  debounce #(
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_step_debounce (
    .clk  (clk),
    .rst  (rst),
    .din  (step_btn),
    .dout (btn_level_s),
    .rise (btn_rise_s)
  );

  // Next state, divider next value, next tick and next running flag.
  always_comb begin
    mode_s         = clk_mode_t'(mode);
    state_next_s   = decode_mode(mode_s);
    mode_chg_s     = (mode_s != mode_r);
    auto_s         = 1'b0;
    div_term_s     = SLOW_TERM;
    div_cnt_next_s = {CW{1'b0}};
    tick_next_s    = 1'b0;

    case (state_r)
      S_SLOW: begin
        auto_s     = 1'b1;
        div_term_s = SLOW_TERM;
      end
      S_FAST: begin
        auto_s     = 1'b1;
        div_term_s = FAST_TERM;
      end
      S_HALT: begin
        auto_s     = 1'b0;
        div_term_s = SLOW_TERM;
      end
      S_STEP: begin
        auto_s     = 1'b0;
        div_term_s = SLOW_TERM;
      end
      default: begin
        auto_s     = 1'b0;
        div_term_s = SLOW_TERM;
      end
    endcase

    // halt_r (not halt_req) gates the divider so a tick already in flight
    // when the CPU raises halt_req is still delivered.
    div_hold_s = !auto_s || halt_r || mode_chg_s;

    if (div_hold_s) begin
      div_cnt_next_s = {CW{1'b0}};
    end else if (div_cnt_r == div_term_s) begin
      div_cnt_next_s = {CW{1'b0}};
    end else begin
      div_cnt_next_s = div_cnt_r + CW'(1'b1);
    end

    // tick is high in the cycle the counter sits at its terminal value, so a
    // fresh count from 0 produces its first tick DIV cycles after entry.
    if (state_r == S_STEP) begin
      // rise only ever pulses together with a high level; requiring both keeps
      // a corrupted rise pulse from issuing a step.
      tick_next_s = btn_rise_s && btn_level_s;
    end else begin
      tick_next_s = !div_hold_s && (div_cnt_next_s == div_term_s);
    end

    // Never fire on a mode switch, never two cycles in a row.
    tick_next_s = tick_next_s && !mode_chg_s && !tick_r;

    running_next_s = ((state_next_s == S_SLOW) || (state_next_s == S_FAST)) && !halt_req;
  end

  // FSM state register plus the registered copy of mode used for change detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_HALT;
      mode_r  <= MODE_HALT;
    end else begin
      state_r <= state_next_s;
      mode_r  <= mode_s;
    end
  end

  // Divider, halt sampling and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_r       <= 1'b0;
      div_cnt_r    <= {CW{1'b0}};
      tick_r       <= 1'b0;
      running_r    <= 1'b0;
      tick_count_r <= 8'd0;
    end else begin
      halt_r       <= halt_req;
      div_cnt_r    <= div_cnt_next_s;
      tick_r       <= tick_next_s;
      running_r    <= running_next_s;
      tick_count_r <= tick_count_r + {7'd0, tick_next_s};
    end
  end

  assign tick       = tick_r;
  assign running    = running_r;
  assign tick_count = tick_count_r;

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl with small divisors: a table of
// {inputs, cycle count, expected ticks/running/tick_count} segments followed
// by cycle-exact hand-written sequences for the timing corner cases.
module tb_clock_ctrl;
  import td4_pkg::*;

  localparam int unsigned CLK_HZ       = 1000;
  localparam int unsigned SLOW_HZ      = 10;
  localparam int unsigned FAST_HZ      = 100;
  localparam int unsigned DEBOUNCE_CYC = 4;
  localparam int unsigned SYNC_STAGES  = 2;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       step_btn;
  logic       halt_req;
  logic       tick;
  logic       running;
  logic [7:0] tick_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [1:0] mode;
    logic       halt;
    logic       btn;
    int         n;
    int         ticks;
    logic       running;
    int         count;
  } vec_t;

  vec_t vecs[17];

  clock_ctrl #(
    .CLK_HZ       (CLK_HZ),
    .SLOW_HZ      (SLOW_HZ),
    .FAST_HZ      (FAST_HZ),
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .SYNC_STAGES  (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .step_btn   (step_btn),
    .halt_req   (halt_req),
    .tick       (tick),
    .running    (running),
    .tick_count (tick_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; afterwards outputs of that edge are stable and new
  // inputs may be driven for the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp_v);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    mode     = MODE_HALT;
    halt_req = 1'b0;
    step_btn = 1'b0;
    step();
    step();
    check("reset_tick", int'(tick), 0);
    check("reset_running", int'(running), 0);
    check("reset_count", int'(tick_count), 0);
    rst = 1'b0;
    step();
  endtask

  initial begin
    int ticks_seen;
    int dbl;
    logic prev_tick;

    rst      = 1'b1;
    mode     = MODE_HALT;
    halt_req = 1'b0;
    step_btn = 1'b0;

    //            rst   mode       halt  btn   n    ticks run   count
    vecs[0]  = '{1'b1, MODE_HALT, 1'b0, 1'b0, 2,   0,    1'b0, 0};
    vecs[1]  = '{1'b0, MODE_HALT, 1'b0, 1'b0, 50,  0,    1'b0, 0};
    vecs[2]  = '{1'b0, MODE_FAST, 1'b0, 1'b0, 30,  3,    1'b1, 3};
    vecs[3]  = '{1'b0, MODE_FAST, 1'b1, 1'b0, 40,  0,    1'b0, 3};
    vecs[4]  = '{1'b0, MODE_FAST, 1'b0, 1'b0, 25,  2,    1'b1, 5};
    vecs[5]  = '{1'b0, MODE_STEP, 1'b0, 1'b1, 20,  1,    1'b0, 6};
    vecs[6]  = '{1'b0, MODE_STEP, 1'b1, 1'b1, 20,  0,    1'b0, 6};
    vecs[7]  = '{1'b0, MODE_STEP, 1'b1, 1'b0, 20,  0,    1'b0, 6};
    vecs[8]  = '{1'b0, MODE_STEP, 1'b1, 1'b1, 20,  1,    1'b0, 7};
    vecs[9]  = '{1'b0, MODE_FAST, 1'b0, 1'b0, 10,  1,    1'b1, 8};
    vecs[10] = '{1'b0, MODE_FAST, 1'b0, 1'b1, 9,   0,    1'b1, 8};
    vecs[11] = '{1'b0, MODE_STEP, 1'b0, 1'b1, 20,  0,    1'b0, 8};
    vecs[12] = '{1'b0, MODE_STEP, 1'b0, 1'b0, 20,  0,    1'b0, 8};
    vecs[13] = '{1'b0, MODE_SLOW, 1'b0, 1'b0, 100, 1,    1'b1, 9};
    vecs[14] = '{1'b0, MODE_SLOW, 1'b0, 1'b0, 99,  0,    1'b1, 9};
    vecs[15] = '{1'b1, MODE_SLOW, 1'b0, 1'b0, 1,   0,    1'b0, 0};
    vecs[16] = '{1'b0, MODE_SLOW, 1'b0, 1'b0, 100, 1,    1'b1, 1};

    prev_tick = 1'b0;
    for (int i = 0; i < 17; i++) begin
      rst        = vecs[i].rst;
      mode       = vecs[i].mode;
      halt_req   = vecs[i].halt;
      step_btn   = vecs[i].btn;
      ticks_seen = 0;
      dbl        = 0;
      for (int c = 1; c <= vecs[i].n; c++) begin
        step();
        if (tick === 1'b1) begin
          ticks_seen++;
          if (prev_tick) dbl = 1;
        end
        prev_tick = tick;
      end
      check($sformatf("vec%0d_ticks", i), ticks_seen, vecs[i].ticks);
      check($sformatf("vec%0d_running", i), int'(running), int'(vecs[i].running));
      check($sformatf("vec%0d_count", i), int'(tick_count), vecs[i].count);
      check($sformatf("vec%0d_back_to_back", i), dbl, 0);
    end

    // SLOW for 500 cycles: ticks at 100, 200, ... 500.
    do_reset();
    mode = MODE_SLOW;
    for (int c = 1; c <= 500; c++) begin
      step();
      check($sformatf("slow_tick_c%0d", c), int'(tick), (c % 100 == 0) ? 1 : 0);
    end
    check("slow_count", int'(tick_count), 5);
    check("slow_running", int'(running), 1);

    // FAST for 95 cycles (9 ticks), then SLOW: next tick 100 cycles later.
    mode = MODE_FAST;
    for (int c = 1; c <= 95; c++) begin
      step();
      check($sformatf("fast_tick_c%0d", c), int'(tick), (c % 10 == 0) ? 1 : 0);
    end
    mode = MODE_SLOW;
    for (int c = 1; c <= 100; c++) begin
      step();
      check($sformatf("switch_tick_c%0d", c), int'(tick), (c == 100) ? 1 : 0);
    end
    check("switch_count", int'(tick_count), 15);

    // SLOW with halt_req high from cycle 50 until cycle 250.
    do_reset();
    mode = MODE_SLOW;
    for (int c = 1; c <= 360; c++) begin
      step();
      check($sformatf("halt_tick_c%0d", c), int'(tick), (c == 350) ? 1 : 0);
      check($sformatf("halt_running_c%0d", c), int'(running), (c >= 51 && c <= 250) ? 0 : 1);
      if (c == 50) halt_req = 1'b1;
      if (c == 250) halt_req = 1'b0;
    end
    check("halt_count", int'(tick_count), 1);

    // One-cycle reset mid-FAST with the divider at 7.
    do_reset();
    mode = MODE_FAST;
    for (int c = 1; c <= 8; c++) begin
      step();
      check($sformatf("rstmid_pre_c%0d", c), int'(tick), 0);
    end
    check("rstmid_running_before", int'(running), 1);
    rst = 1'b1;
    step();
    check("rstmid_tick", int'(tick), 0);
    check("rstmid_running", int'(running), 0);
    check("rstmid_count", int'(tick_count), 0);
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      check($sformatf("rstmid_tick_c%0d", c), int'(tick), (c == 10) ? 1 : 0);
      check($sformatf("rstmid_run_c%0d", c), int'(running), 1);
    end
    check("rstmid_count_after", int'(tick_count), 1);

    // STEP: 3-cycle glitch, clean 20-cycle press, release.
    do_reset();
    mode = MODE_STEP;
    for (int c = 1; c <= 5; c++) begin
      step();
      check($sformatf("step_idle_c%0d", c), int'(tick), 0);
    end
    step_btn = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step();
      check($sformatf("glitch_tick_c%0d", c), int'(tick), 0);
      if (c == 3) step_btn = 1'b0;
    end
    step_btn = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      check($sformatf("press_tick_c%0d", c), int'(tick),
            (c == int'(SYNC_STAGES) + 5) ? 1 : 0);
      if (c == 20) step_btn = 1'b0;
    end
    check("press_count", int'(tick_count), 1);

    // 256 clean presses wrap tick_count back to 0.
    do_reset();
    mode = MODE_STEP;
    step();
    step();
    step();
    for (int p = 0; p < 256; p++) begin
      step_btn = 1'b1;
      for (int c = 1; c <= 20; c++) begin
        step();
        check($sformatf("wrap_p%0d_c%0d", p, c), int'(tick), (c == 7) ? 1 : 0);
        if (c == 10) step_btn = 1'b0;
      end
      if (p == 254) check("wrap_count_255", int'(tick_count), 255);
    end
    check("wrap_count_0", int'(tick_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
Generalised successor to the fixed-ratio prescaler. It produces a single-cycle clock-enable pulse (`tick`) for the CPU core instead of a derived clock, so the whole design stays on `clk`. The pulse rate is selectable at run time between halt, slow auto-run, fast auto-run and manual single-step from a debounced push button. The block sits between the board pins and the control bus; `ctrl.clk` stays on the board clock and CPU registers qualify their updates with `tick`.

Parameters:
- CLK_HZ, 100_000_000, board clock frequency in Hz.
- SLOW_HZ, 1, tick rate in SLOW mode; must divide CLK_HZ.
- FAST_HZ, 10, tick rate in FAST mode; must divide CLK_HZ; FAST_HZ >= SLOW_HZ.
- DEBOUNCE_CYC, 1_000_000, number of consecutive stable synchronised samples required before the button state is accepted (10 ms at 100 MHz).
- SYNC_STAGES, 2, flip-flop stages in the button synchroniser; minimum 2.

Ports:
- clk, input, 1, board clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- mode, input, 2, run mode: 00 HALT, 01 SLOW, 10 FAST, 11 STEP. Assumed quasi-static (switch input).
- step_btn, input, 1, raw asynchronous push button, active-high.
- halt_req, input, 1, level from the CPU; when high, auto-run ticks are suppressed.
- tick, output, 1, one-cycle clock-enable pulse to the CPU.
- running, output, 1, high while SLOW or FAST mode is active and halt_req is low.
- tick_count, output, 8, wrapping count of ticks issued; LED and debug visibility.

Behaviour:
- Reset values:
  - tick = 0, running = 0, tick_count = 0.
  - Divider counter = 0, synchroniser = 0, debounce counter = 0, debounced button = 0.
- Divider:
  - Counter width is $clog2(CLK_HZ/SLOW_HZ).
  - Terminal value is DIV-1, where DIV = CLK_HZ/SLOW_HZ in SLOW and CLK_HZ/FAST_HZ in FAST.
  - On reaching the terminal value: counter returns to 0 and tick = 1 for exactly one cycle.
  - First tick after entering an auto mode arrives DIV cycles after entry.
- Mode change: a registered copy of mode is compared every cycle; any change clears the divider counter to 0 in that cycle and suppresses tick in that cycle.
- HALT (00): divider held at 0; tick = 0.
- halt_req high in SLOW/FAST:
  - Divider held at 0; no tick; running = 0.
  - On release, counting restarts from 0.
  - A tick and the rising edge of halt_req in the same cycle: the tick is still issued; halt_req is a registered response.
- STEP (11):
  - step_btn -> SYNC_STAGES flop synchroniser -> debouncer.
  - Debouncer: if the synchronised value differs from the debounced value, the counter increments, otherwise it clears. When the counter reaches DEBOUNCE_CYC-1, the debounced value flips and the counter clears.
  - A rising edge of the debounced value gives tick = 1 for one cycle. Falling edges and held presses give nothing. Latency from a stable press to tick is SYNC_STAGES + DEBOUNCE_CYC + 1 cycles.
  - halt_req does not block STEP ticks (lets the operator step past HLT for debug).
  - In non-STEP modes the debouncer keeps running but its edges are ignored, so a button held across a mode change does not fire.
- State machine (registered, enum):
  - States: S_HALT, S_SLOW, S_FAST, S_STEP.
  - Next state = decode(mode) every cycle.
  - running = (state == S_SLOW || state == S_FAST) && !halt_req.
- tick_count: increments on every tick; wraps 255 -> 0.
- Reset mid-operation: all state returns to reset values on the next edge; a tick that would have been issued in the reset cycle is dropped.
- tick is never high for two consecutive cycles in any mode.

Decomposition:
- Shared package td4_pkg:
  - typedef enum logic [1:0] clk_mode_t {MODE_HALT, MODE_SLOW, MODE_FAST, MODE_STEP}, reused by the mother board and the IO decode.
  - Localparam helper for the divider width.
- One sub-module: debounce (parameters SYNC_STAGES and DEBOUNCE_CYC; ports clk, rst, din, dout, rise). Reusable for reset and other buttons.
- Divider, mode FSM and counter live in clock_ctrl.

Test Plan:
Bench parameters: CLK_HZ = 1000, SLOW_HZ = 10, FAST_HZ = 100, DEBOUNCE_CYC = 4.
- Reset, then SLOW mode held 500 cycles -> ticks exactly at cycles 100, 200, 300, 400, 500 after entry; tick_count = 5; running = 1.
- FAST mode for 95 cycles, then switch to SLOW -> 9 ticks in FAST; divider clears on the switch; next tick comes 100 cycles after the switch.
- SLOW mode with halt_req = 1 from cycle 50 to 250 -> no ticks while halted; running = 0; first tick at cycle 350 (100 cycles after release).
- STEP mode:
  - 3-cycle glitch on step_btn -> no tick.
  - Clean 20-cycle press -> exactly one tick, SYNC_STAGES + 5 cycles after the press starts.
  - Release -> no tick.
- STEP with 256 clean presses -> tick_count wraps to 0.
- rst asserted for 1 cycle mid-FAST count at counter = 7 -> all outputs 0 next cycle; next tick 10 cycles after reset release.
